l2_axi_line_bridge: RTL
=======================

# l2_axi_line_bridge

Converts whole-cache-line memory requests from the L2 cache miss/writeback path into single AXI4 bursts on the external memory port, and returns completed fills or write acknowledgements. Sits directly between the L2 cache (upstream) and the SoC AXI master port (downstream). A 512-bit line is carried as a 16-beat burst of 32-bit words. One transaction is outstanding at a time.

## Interface
- `DATA_WIDTH`, default 32 (`AXI_DATA_WIDTH`): AXI data bus width.
- `LINE_BITS`, default 512 (`CACHE_LINE_BITS`): cache line width.
  - Derived: BEATS = LINE_BITS/DATA_WIDTH = 16.
  - LINE_BITS must be an exact multiple of DATA_WIDTH.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: bridge idle and able to accept a request.
- `req_is_write` in 1: 1 = writeback, 0 = line fill.
- `req_line` in 26: `cache_line_index_t`, the line address.
- `req_data` in LINE_BITS: writeback data. Ignored for reads.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_is_write` out 1: type of the completed transaction.
- `rsp_data` out LINE_BITS: fill data. Valid while `rsp_valid` is high for reads.
- AXI master, flattened `axi_interface.master` signals:
  - Write address: `awaddr` out 32, `awlen` out 8, `awvalid` out 1, `awready` in 1.
  - Write data: `wdata` out DATA_WIDTH, `wlast` out 1, `wvalid` out 1, `wready` in 1.
  - Write response: `bvalid` in 1, `bready` out 1.
  - Read address: `araddr` out 32, `arlen` out 8, `arvalid` out 1, `arready` in 1.
  - Read data: `rvalid` in 1, `rdata` in DATA_WIDTH, `rready` out 1.

## Operation
- States: IDLE, AW, W, B, AR, R, RSP.
- IDLE
  - `req_ready`=1.
  - On `req_valid`, latch `req_is_write`, `req_line` and `req_data`, clear the beat counter, then go to AW (write) or AR (read).
- AW
  - `awvalid`=1, `awaddr`={line,6'b0}, `awlen`=BEATS-1=15.
  - On `awready` go to W.
- W
  - `wvalid`=1, `wdata`=beat[cnt], where beat i = line[LINE_BITS-1-i*32 -: 32]. The most significant word goes first.
  - `wlast`=(cnt==15).
  - Each `wvalid&&wready` increments cnt.
  - The handshake with cnt==15 goes to B.
- B
  - `bready`=1.
  - On `bvalid` go to RSP.
- AR
  - `arvalid`=1, `araddr`={line,6'b0}, `arlen`=15.
  - On `arready` go to R.
- R
  - `rready`=1.
  - Each `rvalid` writes `rdata` into beat[cnt] of the line register (same word order as W) and increments cnt.
  - The 16th beat goes to RSP.
- RSP
  - `rsp_valid`=1 for exactly one cycle, `rsp_is_write`=latched type, `rsp_data`=assembled line.
  - Then return to IDLE.
  - No backpressure: the consumer must accept the pulse.
- Output gating:
  - `awvalid`, `wvalid`, `bready`, `arvalid` and `rready` are high only in their own state.
  - Channel inputs arriving outside the matching state are ignored.
- The beat counter is 4 bits and wraps naturally. State transitions use the cnt==15 handshake, never the wrap.
- Address outputs and `awlen`/`arlen` are constant while their valid is high (AXI stability rule).

## Timing
- Reset (async assert, sync release):
  - State returns to IDLE and cnt is cleared.
  - `req_ready`=1.
  - `rsp_valid`=0, `rsp_is_write`=0, `rsp_data`=0.
  - All AXI valid/ready/last outputs and `awaddr`, `araddr`, `awlen`, `arlen`, `wdata` are 0.
- Reset mid-burst abandons the transaction immediately. No response is produced.
- A request accepted in cycle 0 raises `awvalid`/`arvalid` in cycle 1. Outputs are registered or state-decoded; there is no combinational path from `req_*` to AXI outputs.
- Minimum write latency (all readies high, `bvalid` at first opportunity):
  - AW in cycle 1, W beats in cycles 2–17, B in 18, `rsp_valid` in 19.
- Minimum read latency:
  - AR in cycle 1, R beats in cycles 2–17, `rsp_valid` in 18.
- `req_ready` is 0 from the cycle after acceptance until IDLE is re-entered. The earliest next acceptance is the cycle after RSP.
- Stalls: deasserting any ready/valid input holds the current beat, counter and outputs unchanged.

## Test plan
- Reset check: assert `reset_n`=0 → all outputs at reset values, `req_ready`=1.
  - Then deassert reset with no request → no AXI activity for 20 cycles.
- Write, all readies tied high: line 0x0000010, data words 0x0..0xF (MSW=0x0).
  - `awaddr`=0x400, `awlen`=15.
  - Beats 0x0..0xF in cycles 2–17, `wlast` only on 0xF.
  - `bvalid` at 18 → `rsp_valid`=1, `rsp_is_write`=1 at 19.
- Read: line 0x3FFFFFF, slave returns 0xA0..0xAF.
  - `araddr`=0xFFFFFFC0.
  - `rsp_data` MSW=0xA0, LSW=0xAF, `rsp_valid` at 18.
- Backpressure: `awready` delayed 3 cycles, `wready` toggling every other cycle, `rvalid` with random gaps.
  - Beat order, `wlast` placement and data are unchanged.
  - `awvalid`/`awaddr` stay stable while waiting.
- Stray inputs and busy check:
  - `bvalid` and `rvalid` pulsed while IDLE → ignored.
  - `req_valid` held during a burst → `req_ready` stays 0, and back-to-back requests complete in order.
- Async reset asserted during W beat 7 → outputs clear in the same cycle, no `rsp_valid`.
  - A following read then completes normally.

Source files
------------

// File: rtl/l2_axi_line_bridge.sv
// L2 line bridge: turns one whole-cache-line fill or writeback into a single
// fixed-length AXI4 burst and reports completion with a one-cycle pulse.
module l2_axi_line_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_BITS  = 512
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // upstream request from the L2 miss / writeback path
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_write,
  input  logic [25:0]           req_line,
  input  logic [LINE_BITS-1:0]  req_data,
  // completion back to the L2
  output logic                  rsp_valid,
  output logic                  rsp_is_write,
  output logic [LINE_BITS-1:0]  rsp_data,
  // AXI write address
  output logic [31:0]           awaddr,
  output logic [7:0]            awlen,
  output logic                  awvalid,
  input  logic                  awready,
  // AXI write data
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  // AXI write response
  input  logic                  bvalid,
  output logic                  bready,
  // AXI read address
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic                  arvalid,
  input  logic                  arready,
  // AXI read data
  input  logic                  rvalid,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rready,
  // current FSM state, for debug and checker binding
  output logic [2:0]            dbg_state
);

  // LINE_BITS must be an exact multiple of DATA_WIDTH.
  localparam int BEATS = LINE_BITS / DATA_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_BITS / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [7:0]       BURST_LEN = 8'(BEATS - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_RSP  = 3'd6
  } state_t;

  state_t                             state;
  logic [CNT_W-1:0]                   cnt;
  logic                               is_write_q;
  logic [25:0]                        line_q;
  logic [BEATS-1:0][DATA_WIDTH-1:0]   line_words;
  logic [CNT_W-1:0]                   beat_idx;
  logic [31:0]                        line_addr;

  // Beat 0 is the most significant word of the line, so the word slot
  // counts down while the beat counter counts up.
  assign beat_idx  = LAST_BEAT - cnt;
  assign line_addr = 32'({line_q, OFF_W'(0)});

  // Handshakes are strict AXI valid/ready: a transfer happens on a rising
  // edge where both are high; the bridge never drops a valid it has raised
  // and its address/len/data stay constant until the transfer. Channel
  // inputs are only looked at in the state that owns that channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      is_write_q <= 1'b0;
      line_q     <= '0;
      line_words <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            is_write_q <= req_is_write;
            line_q     <= req_line;
            line_words <= req_data;
            cnt        <= '0;
            state      <= req_is_write ? ST_AW : ST_AR;
          end
        end
        ST_AW: begin
          if (awready) state <= ST_W;
        end
        ST_W: begin
          if (wready) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) state <= ST_B;
          end
        end
        ST_B: begin
          if (bvalid) state <= ST_RSP;
        end
        ST_AR: begin
          if (arready) state <= ST_R;
        end
        ST_R: begin
          if (rvalid) begin
            line_words[beat_idx] <= rdata;
            cnt                  <= cnt + 1'b1;
            if (cnt == LAST_BEAT) state <= ST_RSP;
          end
        end
        ST_RSP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // All outputs decode from registered state only; nothing on req_* reaches
  // the AXI side combinationally.
  assign req_ready    = (state == ST_IDLE);
  assign awvalid      = (state == ST_AW);
  assign awaddr       = awvalid ? line_addr : '0;
  assign awlen        = awvalid ? BURST_LEN : '0;
  assign wvalid       = (state == ST_W);
  assign wdata        = wvalid ? line_words[beat_idx] : '0;
  assign wlast        = wvalid && (cnt == LAST_BEAT);
  assign bready       = (state == ST_B);
  assign arvalid      = (state == ST_AR);
  assign araddr       = arvalid ? line_addr : '0;
  assign arlen        = arvalid ? BURST_LEN : '0;
  assign rready       = (state == ST_R);
  assign rsp_valid    = (state == ST_RSP);
  assign rsp_is_write = is_write_q;
  assign rsp_data     = line_words;
  assign dbg_state    = state;

endmodule
